flexsipo: RTL and testbench

FLEXSIPO -- requirements
Module: flexsipo

---
 rtl/flexsipo_pkg.sv | 22 ++
 rtl/flexsipo.sv | 144 ++++++++++++++
 tb/tb_flexsipo.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flexsipo_pkg.sv
// Purpose: types and default sizes shared by the flexsipo / flexpiso pair.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package flexsipo_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_SHIFT_LENGTH = 12;
  localparam int DEF_IS_COMP      = 1;

  // One complex sample at the default width (I first, Q second).
  typedef struct packed {
    logic signed [DEF_DATA_WIDTH-1:0] i;
    logic signed [DEF_DATA_WIDTH-1:0] q;
  } sample_t;

  // Frame collector states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

endpackage

// File: rtl/flexsipo.sv
// Purpose: serial-in / parallel-out frame collector with a per-frame length.
// Latency: last sample accepted at edge N -> o_pout valid, o_done=1 in cycle N+1.
// Backpressure: none; every i_valid sample is taken (i_flush discards it).
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_valid, i_sin  serial sample and qualifier
//   i_limit         frame length, latched on the first sample of a frame
//                   (0 or > SHIFT_LENGTH means SHIFT_LENGTH)
//   i_flush         abort the partial frame
//   o_pout          last completed frame (double buffered)
//   o_done          one-cycle pulse when o_pout takes a new frame
//   o_busy, o_count collection in progress / samples collected so far
module flexsipo
  import flexsipo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int SHIFT_LENGTH = DEF_SHIFT_LENGTH,
  parameter int IS_COMP      = DEF_IS_COMP
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_valid,
  input  logic signed [DATA_WIDTH-1:0]       i_sin  [0:IS_COMP],
  input  logic [$clog2(SHIFT_LENGTH):0]      i_limit,
  input  logic                               i_flush,
  output logic signed [DATA_WIDTH-1:0]       o_pout [0:SHIFT_LENGTH-1][0:IS_COMP],
  output logic                               o_done,
  output logic                               o_busy,
  output logic [$clog2(SHIFT_LENGTH):0]      o_count
);

  localparam int              CW      = $clog2(SHIFT_LENGTH) + 1;
  localparam logic [CW-1:0]   LIM_MAX = CW'(SHIFT_LENGTH);

  state_t                        state_q, state_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [CW-1:0]                 lim_q, lim_d;
  logic                          done_q, done_d;
  logic                          pout_ld;
  logic signed [DATA_WIDTH-1:0]  work_q [0:SHIFT_LENGTH-1][0:IS_COMP];
  logic signed [DATA_WIDTH-1:0]  work_d [0:SHIFT_LENGTH-1][0:IS_COMP];
  logic signed [DATA_WIDTH-1:0]  pout_q [0:SHIFT_LENGTH-1][0:IS_COMP];

  logic                          accept;
  logic [CW-1:0]                 lim_in;
  logic [CW-1:0]                 frame_lim;
  logic [CW-1:0]                 count_inc;
  logic [CW-1:0]                 wr_idx;

  assign accept    = i_valid & ~i_flush;
  assign lim_in    = ((i_limit == '0) || (i_limit > LIM_MAX)) ? LIM_MAX : i_limit;
  // The first sample of a frame is judged against the length being latched
  // on that same edge, so a length-1 frame completes immediately.
  assign frame_lim = (state_q == ST_IDLE) ? lim_in : lim_q;
  assign count_inc = count_q + CW'(1);
  // Sample k lands at SHIFT_LENGTH-1-k, mirroring flexpiso's shift-out order.
  assign wr_idx    = LIM_MAX - CW'(1) - count_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lim_d   = lim_q;
    done_d  = 1'b0;
    pout_ld = 1'b0;
    work_d  = work_q;

    case (state_q)
      ST_FILL: begin
        if (i_flush) begin
          for (int i = 0; i < SHIFT_LENGTH; i++)
            for (int c = 0; c <= IS_COMP; c++)
              work_d[i][c] = '0;
          state_d = ST_IDLE;
          count_d = '0;
        end
      end
      default: begin
        if (accept) begin
          // Fresh frame: clear leftovers from any longer earlier frame.
          lim_d = lim_in;
          for (int i = 0; i < SHIFT_LENGTH; i++)
            for (int c = 0; c <= IS_COMP; c++)
              work_d[i][c] = '0;
        end
      end
    endcase

    if (accept) begin
      for (int i = 0; i < SHIFT_LENGTH; i++)
        if (CW'(i) == wr_idx)
          for (int c = 0; c <= IS_COMP; c++)
            work_d[i][c] = i_sin[c];

      if (count_inc == frame_lim) begin
        pout_ld = 1'b1;
        done_d  = 1'b1;
        count_d = '0;
        state_d = ST_IDLE;
      end else begin
        count_d = count_inc;
        state_d = ST_FILL;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
      lim_q   <= LIM_MAX;
      done_q  <= 1'b0;
      for (int i = 0; i < SHIFT_LENGTH; i++)
        for (int c = 0; c <= IS_COMP; c++) begin
          work_q[i][c] <= '0;
          pout_q[i][c] <= '0;
        end
    end else begin
      count_q <= count_d;
      lim_q   <= lim_d;
      done_q  <= done_d;
      for (int i = 0; i < SHIFT_LENGTH; i++)
        for (int c = 0; c <= IS_COMP; c++) begin
          work_q[i][c] <= work_d[i][c];
          // Load from the next-state buffer so the completing sample is included.
          if (pout_ld)
            pout_q[i][c] <= work_d[i][c];
        end
    end
  end

  assign o_pout  = pout_q;
  assign o_done  = done_q;
  assign o_busy  = (state_q == ST_FILL);
  assign o_count = count_q;

endmodule

// File: tb/tb_flexsipo.sv
// Purpose: self-checking bench for flexsipo with a frame scoreboard.
// Latency: expects o_done in the cycle after the frame's last accepted sample.
// Backpressure: n/a (drives the serial side every cycle).
module tb_flexsipo;
  import flexsipo_pkg::*;

  localparam int DW = 8;
  localparam int SL = 12;
  localparam int IC = 1;
  localparam int CW = $clog2(SL) + 1;
  localparam int FW = SL * 2 * DW;

  logic                 i_clk   = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic                 i_valid = 1'b0;
  logic                 i_flush = 1'b0;
  logic signed [DW-1:0] i_sin [0:IC];
  logic [CW-1:0]        i_limit = '0;
  logic signed [DW-1:0] o_pout [0:SL-1][0:IC];
  logic                 o_done;
  logic                 o_busy;
  logic [CW-1:0]        o_count;

  flexsipo #(.DATA_WIDTH(DW), .SHIFT_LENGTH(SL), .IS_COMP(IC)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_sin   (i_sin),
    .i_limit (i_limit),
    .i_flush (i_flush),
    .o_pout  (o_pout),
    .o_done  (o_done),
    .o_busy  (o_busy),
    .o_count (o_count)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [FW-1:0] frame;
    int            at;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic [FW-1:0] ef;
  logic [FW-1:0] last_frame;

  function automatic logic [FW-1:0] pack_pout();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < SL; i++)
      for (int c = 0; c <= IC; c++)
        f[(i*2+c)*DW +: DW] = o_pout[i][c];
    return f;
  endfunction

  function automatic logic [FW-1:0] put(logic [FW-1:0] f, int idx, int re, int im);
    logic [FW-1:0] r;
    r = f;
    r[(idx*2)*DW +: DW]   = DW'(re);
    r[(idx*2+1)*DW +: DW] = DW'(im);
    return r;
  endfunction

  task automatic chk(string name, logic [FW-1:0] act, logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; inputs change 1 time unit after the edge.
  task automatic step(bit v, int re, int im, bit fl, int lim);
    i_valid = v;
    i_sin[0] = DW'(re);
    i_sin[1] = DW'(im);
    i_flush = fl;
    i_limit = CW'(lim);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  // Called right after the edge that took a frame's last sample.
  task automatic expect_frame(logic [FW-1:0] f);
    sb.push_back('{frame: f, at: cyc});
    last_frame = f;
  endtask

  // Monitor: every o_done must match the oldest expected frame and cycle.
  always @(negedge i_clk) begin
    if (i_rst_n && o_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("frame", pack_pout(), mon_e.frame);
        chk("done_cycle", FW'(cyc), FW'(mon_e.at));
      end
    end
  end

  int lb_lims [5] = '{0, 1, 7, 12, 20};

  initial begin
    i_sin[0] = '0;
    i_sin[1] = '0;
    last_frame = '0;

    // Reset state.
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_done",  FW'(o_done),  '0);
    chk("rst_busy",  FW'(o_busy),  '0);
    chk("rst_count", FW'(o_count), '0);
    chk("rst_pout",  pack_pout(),  '0);
    i_rst_n = 1'b1;
    idle(2);

    // Full frame, (k,-k) for k=1..12, continuous.
    ef = '0;
    for (int k = 1; k <= 12; k++) begin
      step(1, k, -k, 0, 12);
      ef = put(ef, 12 - k, k, -k);
      if (k == 6) begin
        chk("mid_count", FW'(o_count), FW'(6));
        chk("mid_busy",  FW'(o_busy),  FW'(1));
      end
    end
    expect_frame(ef);
    idle(2);

    // Limit 5 with 2-cycle gaps; o_pout keeps the previous frame meanwhile.
    ef = '0;
    for (int k = 1; k <= 5; k++) begin
      step(1, k, -k, 0, 5);
      ef = put(ef, 12 - k, k, -k);
      if (k == 3) begin
        chk("gap_count", FW'(o_count), FW'(3));
        chk("hold_pout", pack_pout(), last_frame);
      end
      if (k < 5) idle(2);
    end
    expect_frame(ef);
    idle(2);

    // Back-to-back: limit 12 then limit 3, no idle cycle between.
    ef = '0;
    for (int k = 1; k <= 12; k++) begin
      step(1, 20 + k, -(20 + k), 0, 12);
      ef = put(ef, 12 - k, 20 + k, -(20 + k));
    end
    expect_frame(ef);
    ef = '0;
    ef = put(ef, 11, 51, -51);
    ef = put(ef, 10, 52, -52);
    ef = put(ef, 9,  53, -53);
    for (int k = 1; k <= 3; k++) step(1, 50 + k, -(50 + k), 0, 3);
    expect_frame(ef);

    // Limit 1: every sample is a frame, continuous.
    for (int k = 1; k <= 3; k++) begin
      step(1, 30 + k, 40 + k, 0, 1);
      ef = '0;
      ef = put(ef, 11, 30 + k, 40 + k);
      expect_frame(ef);
      chk("lim1_busy", FW'(o_busy), '0);
    end
    idle(2);

    // Flush after 4 of 8, with a same-cycle sample to be discarded.
    for (int k = 1; k <= 4; k++) step(1, 90 + k, 0, 0, 8);
    step(1, 99, 99, 1, 8);
    chk("flush_count", FW'(o_count), '0);
    chk("flush_busy",  FW'(o_busy),  '0);
    chk("flush_pout",  pack_pout(),  last_frame);
    // Flush in IDLE with a sample: nothing starts.
    step(1, 77, 77, 1, 5);
    chk("idle_flush_busy",  FW'(o_busy),  '0);
    chk("idle_flush_count", FW'(o_count), '0);
    ef = '0;
    for (int k = 1; k <= 8; k++) begin
      step(1, 60 + k, -(60 + k), 0, 8);
      ef = put(ef, 12 - k, 60 + k, -(60 + k));
    end
    expect_frame(ef);
    idle(2);

    // Reset pulse mid-frame.
    for (int k = 1; k <= 6; k++) step(1, 100 + k, 0, 0, 12);
    i_rst_n = 1'b0;
    #1;
    chk("mrst_pout",  pack_pout(),  '0);
    chk("mrst_done",  FW'(o_done),  '0);
    chk("mrst_busy",  FW'(o_busy),  '0);
    chk("mrst_count", FW'(o_count), '0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    idle(1);
    ef = '0;
    for (int k = 1; k <= 12; k++) begin
      step(1, k + 2, k + 5, 0, 12);
      ef = put(ef, 12 - k, k + 2, k + 5);
    end
    expect_frame(ef);
    idle(2);

    // Loopback: serialize a parallel frame the way flexpiso does
    // (highest index first) and expect it back over the used indices.
    foreach (lb_lims[t]) begin
      int L;
      L = (lb_lims[t] == 0 || lb_lims[t] > SL) ? SL : lb_lims[t];
      ef = '0;
      for (int i = SL - L; i < SL; i++) ef = put(ef, i, i + 1 + 10 * t, -(i + 3));
      for (int k = 0; k < L; k++) begin
        int idx;
        idx = SL - 1 - k;
        step(1, idx + 1 + 10 * t, -(idx + 3), 0, lb_lims[t]);
      end
      expect_frame(ef);
      idle(1);
    end

    idle(3);
    chk("sb_empty", FW'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
